// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595-style shift-register chain controller.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_e;

    localparam int BITS_PER_DEV = 8;

    function automatic int word_width(input int n_dev);
        return BITS_PER_DEV * n_dev;
    endfunction

endpackage

// File: rtl/hc595_chain_ctrl_if.sv
// Parallel-word valid/ready handshake between the bus logic and the chain controller.
interface hc595_chain_ctrl_if
    import hc595_pkg::*;
#(
    parameter int N_DEV = 2
) ();

    localparam int WORD_W = word_width(N_DEV);

    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/hc595_tick_gen.sv
// Phase timer: pulses phase_end on the last of every CLK_DIV enabled cycles; clear restarts the count.
module hc595_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic phase_end
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign phase_end = en && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear || phase_end) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Shifts a parallel word MSB-first into a chain of 8-bit SIPO registers, then pulses the storage latch.
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int N_DEV   = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    hc595_chain_ctrl_if.slave   s,
    input  logic                oe_en,
    output logic                sh_clk,
    output logic                sh_sin,
    output logic                st_clk,
    output logic                oe_n,
    output logic                busy,
    output logic                done
);

    localparam int WORD_W = word_width(N_DEV);
    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              latched_once_q, latched_once_d;
    logic              s_ready_q, s_ready_d;
    logic              sh_clk_q, sh_clk_d;
    logic              sh_sin_q, sh_sin_d;
    logic              st_clk_q, st_clk_d;
    logic              oe_n_q, oe_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic phase_end;
    logic tick_en;
    logic tick_clear;

    assign tick_en    = (state_q != IDLE);
    assign tick_clear = (state_d != state_q);

    hc595_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (tick_en),
        .clear     (tick_clear),
        .phase_end (phase_end)
    );

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        latched_once_d = latched_once_q;

        unique case (state_q)
            IDLE: begin
                if (s.s_valid && s_ready_q) begin
                    shift_d   = s.s_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    state_d   = (bit_cnt_q == LAST_BIT) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    latched_once_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so the registered pins line up with the state register.
    always_comb begin
        s_ready_d = (state_d == IDLE);
        sh_clk_d  = (state_d == SHIFT_HI);
        sh_sin_d  = (state_d == SHIFT_LO) ? shift_d[WORD_W-1] : sh_sin_q;
        st_clk_d  = (state_d == LATCH);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == LATCH) && (state_d == IDLE);
        oe_n_d    = ~(oe_en && latched_once_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            latched_once_q <= 1'b0;
            s_ready_q      <= 1'b0;
            sh_clk_q       <= 1'b0;
            sh_sin_q       <= 1'b0;
            st_clk_q       <= 1'b0;
            oe_n_q         <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            latched_once_q <= latched_once_d;
            s_ready_q      <= s_ready_d;
            sh_clk_q       <= sh_clk_d;
            sh_sin_q       <= sh_sin_d;
            st_clk_q       <= st_clk_d;
            oe_n_q         <= oe_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign s.s_ready = s_ready_q;
    assign sh_clk    = sh_clk_q;
    assign sh_sin    = sh_sin_q;
    assign st_clk    = st_clk_q;
    assign oe_n      = oe_n_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Directed bench for hc595_chain_ctrl: one 1-device/div-2 instance and one 2-device/div-4 instance.
module tb_hc595_chain_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hc595_chain_ctrl_if #(.N_DEV(1)) bus1 ();
    hc595_chain_ctrl_if #(.N_DEV(2)) bus2 ();

    logic oe_en1, sh_clk1, sh_sin1, st_clk1, oe_n1, busy1, done1;
    logic oe_en2, sh_clk2, sh_sin2, st_clk2, oe_n2, busy2, done2;

    hc595_chain_ctrl #(.N_DEV(1), .CLK_DIV(2)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .s      (bus1),
        .oe_en  (oe_en1),
        .sh_clk (sh_clk1),
        .sh_sin (sh_sin1),
        .st_clk (st_clk1),
        .oe_n   (oe_n1),
        .busy   (busy1),
        .done   (done1)
    );

    hc595_chain_ctrl #(.N_DEV(2), .CLK_DIV(4)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .s      (bus2),
        .oe_en  (oe_en2),
        .sh_clk (sh_clk2),
        .sh_sin (sh_sin2),
        .st_clk (st_clk2),
        .oe_n   (oe_n2),
        .busy   (busy2),
        .done   (done2)
    );

    // Behavioural model of the off-chip chain: shift on sh_clk rise, copy to outputs on st_clk rise.
    logic [7:0]  chain1 = 8'h00;
    logic [7:0]  dout1  = 8'h00;
    logic [15:0] chain2 = 16'h0000;
    logic [15:0] dout2  = 16'h0000;
    int sh_edges1 = 0, st_edges1 = 0, sh_edges2 = 0, st_edges2 = 0;

    always @(posedge sh_clk1) begin
        chain1 = {chain1[6:0], sh_sin1};
        sh_edges1++;
    end

    always @(posedge st_clk1) begin
        dout1 = chain1;
        st_edges1++;
    end

    always @(posedge sh_clk2) begin
        chain2 = {chain2[14:0], sh_sin2};
        sh_edges2++;
    end

    always @(posedge st_clk2) begin
        dout2 = chain2;
        st_edges2++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic test_reset();
        rst = 1'b1;
        oe_en1 = 1'b1;
        oe_en2 = 1'b0;
        bus1.s_valid = 1'b0;
        bus1.s_data  = 8'h00;
        bus2.s_valid = 1'b0;
        bus2.s_data  = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({oe_n1, sh_clk1, st_clk1, busy1, bus1.s_ready, done1} !== 6'b100000) begin
            n_err++;
            $display("[TB] FAIL reset_outputs_dut1 got %b expected 100000",
                     {oe_n1, sh_clk1, st_clk1, busy1, bus1.s_ready, done1});
        end
        n_cmp++;
        if ({oe_n2, sh_clk2, st_clk2, busy2, bus2.s_ready, done2} !== 6'b100000) begin
            n_err++;
            $display("[TB] FAIL reset_outputs_dut2 got %b expected 100000",
                     {oe_n2, sh_clk2, st_clk2, busy2, bus2.s_ready, done2});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus1.s_ready !== 1'b1 || bus2.s_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_ready_after got %b%b expected 11", bus1.s_ready, bus2.s_ready);
        end
        n_cmp++;
        if (oe_n1 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_oe_n_before_latch got %b expected 1", oe_n1);
        end
    endtask

    task automatic test_word_a5();
        int st_first = -1, st_last = -1, done_at = -1, done_cnt = 0;
        int oe_bad = 0, busy_bad = 0;
        int sh0 = sh_edges1, st0 = st_edges1;
        logic oe_after = 1'bx;
        bus1.s_valid = 1'b1;
        bus1.s_data  = 8'hA5;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) bus1.s_valid = 1'b0;
            if (st_clk1 === 1'b1) begin
                if (st_first < 0) st_first = c;
                st_last = c;
            end
            if (done1 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at < 0 && oe_n1 !== 1'b1) oe_bad++;
            if (done_at > 0 && c == done_at + 1) oe_after = oe_n1;
            if (busy1 !== ((done_at < 0) ? 1'b1 : 1'b0)) busy_bad++;
        end
        n_cmp++;
        if (sh_edges1 - sh0 !== 8) begin
            n_err++;
            $display("[TB] FAIL a5_sh_edges got %0d expected 8", sh_edges1 - sh0);
        end
        n_cmp++;
        if (st_edges1 - st0 !== 1) begin
            n_err++;
            $display("[TB] FAIL a5_st_edges got %0d expected 1", st_edges1 - st0);
        end
        n_cmp++;
        if (st_first !== 33 || st_last !== 34) begin
            n_err++;
            $display("[TB] FAIL a5_st_window got %0d..%0d expected 33..34", st_first, st_last);
        end
        n_cmp++;
        if (done_at !== 35 || done_cnt !== 1) begin
            n_err++;
            $display("[TB] FAIL a5_done got cycle %0d count %0d expected cycle 35 count 1", done_at, done_cnt);
        end
        n_cmp++;
        if (dout1 !== 8'hA5) begin
            n_err++;
            $display("[TB] FAIL a5_chain_dout got %h expected a5", dout1);
        end
        n_cmp++;
        if (oe_bad !== 0 || oe_after !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL a5_oe_n got early_low=%0d after=%b expected 0 and 0", oe_bad, oe_after);
        end
        n_cmp++;
        if (busy_bad !== 0) begin
            n_err++;
            $display("[TB] FAIL a5_busy got %0d bad cycles expected 0", busy_bad);
        end
    endtask

    task automatic test_oe_toggle();
        n_cmp++;
        if (oe_n1 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL oe_enabled got %b expected 0", oe_n1);
        end
        oe_en1 = 1'b0;
        oe_en2 = 1'b1;
        #1;
        n_cmp++;
        if (oe_n1 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL oe_registered got %b expected 0", oe_n1);
        end
        @(negedge clk);
        n_cmp++;
        if (oe_n1 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL oe_drop got %b expected 1", oe_n1);
        end
        n_cmp++;
        if (oe_n2 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL oe_unlatched_dut2 got %b expected 1", oe_n2);
        end
        oe_en1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (oe_n1 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL oe_reenable got %b expected 0", oe_n1);
        end
    endtask

    task automatic test_word_8001();
        int st_first = -1, st_last = -1, done_at = -1;
        int sh0 = sh_edges2;
        logic oe_after = 1'bx;
        bus2.s_valid = 1'b1;
        bus2.s_data  = 16'h8001;
        @(posedge clk);
        for (int c = 1; c <= 180; c++) begin
            @(negedge clk);
            if (c == 1) bus2.s_valid = 1'b0;
            if (st_clk2 === 1'b1) begin
                if (st_first < 0) st_first = c;
                st_last = c;
            end
            if (done1 === 1'b1 && done_at < 0) done_at = -2;
            if (done2 === 1'b1 && done_at < 0) done_at = c;
            if (done_at > 0 && c == done_at + 1) oe_after = oe_n2;
        end
        n_cmp++;
        if (sh_edges2 - sh0 !== 16) begin
            n_err++;
            $display("[TB] FAIL 8001_sh_edges got %0d expected 16", sh_edges2 - sh0);
        end
        n_cmp++;
        if (st_first !== 129 || st_last !== 132) begin
            n_err++;
            $display("[TB] FAIL 8001_st_window got %0d..%0d expected 129..132", st_first, st_last);
        end
        n_cmp++;
        if (done_at !== 133) begin
            n_err++;
            $display("[TB] FAIL 8001_done got cycle %0d expected 133", done_at);
        end
        n_cmp++;
        if (dout2[7:0] !== 8'h01 || dout2[15:8] !== 8'h80) begin
            n_err++;
            $display("[TB] FAIL 8001_devices got first=%h second=%h expected 01 80", dout2[7:0], dout2[15:8]);
        end
        n_cmp++;
        if (oe_after !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL 8001_oe_n got %b expected 0", oe_after);
        end
    endtask

    task automatic test_back_to_back();
        int accepted = -1, done_first = -1, done_second = -1, done_cnt = 0;
        logic [7:0] dout_first = 8'hxx;
        logic busy_next = 1'bx;
        bus1.s_valid = 1'b1;
        bus1.s_data  = 8'h5A;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) bus1.s_data = 8'h3C;
            if (accepted > 0 && c == accepted + 1) begin
                bus1.s_valid = 1'b0;
                busy_next = busy1;
            end
            if (done1 === 1'b1) begin
                done_cnt++;
                if (done_first < 0) begin
                    done_first = c;
                    dout_first = dout1;
                end else if (done_second < 0) begin
                    done_second = c;
                end
            end
            if (accepted < 0 && bus1.s_ready === 1'b1) accepted = c;
        end
        n_cmp++;
        if (accepted !== 35 || done_first !== 35) begin
            n_err++;
            $display("[TB] FAIL b2b_accept got ready@%0d done@%0d expected 35 35", accepted, done_first);
        end
        n_cmp++;
        if (dout_first !== 8'h5A) begin
            n_err++;
            $display("[TB] FAIL b2b_first_word got %h expected 5a", dout_first);
        end
        n_cmp++;
        if (busy_next !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_busy_restart got %b expected 1", busy_next);
        end
        n_cmp++;
        if (done_second !== 70 || done_cnt !== 2) begin
            n_err++;
            $display("[TB] FAIL b2b_second_done got cycle %0d count %0d expected 70 2", done_second, done_cnt);
        end
        n_cmp++;
        if (dout1 !== 8'h3C) begin
            n_err++;
            $display("[TB] FAIL b2b_second_word got %h expected 3c", dout1);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int st_seen = 0, done_seen = 0, oe_bad = 0;
        int st0 = st_edges1;
        n_cmp++;
        if (oe_n1 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rstmid_pre_oe got %b expected 0", oe_n1);
        end
        bus1.s_valid = 1'b1;
        bus1.s_data  = 8'hC3;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus1.s_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy1, sh_clk1, st_clk1, oe_n1, bus1.s_ready} !== 5'b00010) begin
            n_err++;
            $display("[TB] FAIL rstmid_async got %b expected 00010",
                     {busy1, sh_clk1, st_clk1, oe_n1, bus1.s_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (st_clk1 === 1'b1) st_seen++;
            if (done1 === 1'b1) done_seen++;
            if (oe_n1 !== 1'b1) oe_bad++;
        end
        n_cmp++;
        if (st_seen !== 0 || done_seen !== 0 || st_edges1 !== st0) begin
            n_err++;
            $display("[TB] FAIL rstmid_no_latch got st=%0d done=%0d edges=%0d expected 0 0 %0d",
                     st_seen, done_seen, st_edges1, st0);
        end
        n_cmp++;
        if (oe_bad !== 0) begin
            n_err++;
            $display("[TB] FAIL rstmid_oe_n got %0d low cycles expected 0", oe_bad);
        end
        n_cmp++;
        if (dout1 !== 8'h3C) begin
            n_err++;
            $display("[TB] FAIL rstmid_dout got %h expected 3c", dout1);
        end
    endtask

    initial begin
        test_reset();
        test_word_a5();
        test_oe_toggle();
        test_word_8001();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
